// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  function automatic int frame_bits(input int data_bits, input int parity_mode, input int stop_bits);
    return 1 + data_bits + ((parity_mode != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with fall-through read data and same-cycle push/pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle
  assign w_push_ok = i_push && (r_count != (AW+1)'(DEPTH));
  assign w_pop_ok  = i_pop && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serialiser with configurable width, parity and stop bits.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_WIDTH    = 9,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
`ifdef UART_TX_BREAK_EN
  input  logic                        tx_break,
`endif
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int                   CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [3:0]           BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);
  localparam parity_mode_e         PAR_CFG   = parity_mode_e'(PARITY_MODE[1:0]);

  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_chk_parity
    $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2 || (2**CNT_WIDTH) < CLKS_PER_BIT) begin : g_chk_baud
    $error("uart_tx_fifo: need CLKS_PER_BIT >= 2 and 2**CNT_WIDTH >= CLKS_PER_BIT");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end

  tx_state_e            r_state, w_state_next;
  logic [CNT_WIDTH-1:0] r_baud, w_baud_next;
  logic [3:0]           r_bit, w_bit_next;
  logic                 r_stop, w_stop_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_par, w_par_next;
  logic                 r_txd, w_txd_next;
  logic                 r_busy, r_ready;
  logic                 w_push, w_pop, w_load, w_full, w_empty, w_bit_end, w_par_load;
  logic [DATA_BITS-1:0] w_rdata;
  logic [CW-1:0]        w_count, w_count_next;
`ifdef UART_TX_BREAK_EN
  logic                 r_mark, w_mark_next;
`endif

  assign w_push       = data_valid && r_ready && !w_full;
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
  assign w_bit_end    = (r_baud == BAUD_LAST);
  assign w_par_load   = (^w_rdata) ^ (PAR_CFG == PAR_ODD);

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (data_in),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next-state and next-bit logic; any path that sets w_load starts a new frame
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = w_bit_end ? '0 : r_baud + CNT_WIDTH'(1);
    w_bit_next   = r_bit;
    w_stop_next  = r_stop;
    w_shift_next = r_shift;
    w_par_next   = r_par;
    w_txd_next   = r_txd;
    w_pop        = 1'b0;
    w_load       = 1'b0;
`ifdef UART_TX_BREAK_EN
    w_mark_next  = r_mark;
`endif
    case (r_state)
      IDLE: begin
        w_baud_next = '0;
        w_txd_next  = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          w_txd_next  = 1'b0;
          w_mark_next = 1'b1;
        end else if (r_mark) begin
          // Mark-after-break: time one full bit from the edge txd returned high
          if (!r_txd) begin
            w_baud_next = '0;
          end else if (w_bit_end) begin
            w_mark_next = 1'b0;
            w_load      = !w_empty;
          end else begin
            w_baud_next = r_baud + CNT_WIDTH'(1);
          end
        end else begin
          w_load = !w_empty;
        end
`else
        w_load = !w_empty;
`endif
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_txd_next   = r_shift[0];
          w_shift_next = r_shift >> 1;
          w_bit_next   = '0;
        end else begin
          w_state_next = START;
        end
      end
      DATA: begin
        if (w_bit_end && r_bit == BIT_LAST) begin
          if (PAR_CFG != PAR_NONE) begin
            w_state_next = PARITY;
            w_txd_next   = r_par;
          end else begin
            w_state_next = STOP;
            w_txd_next   = 1'b1;
            w_stop_next  = 1'b0;
          end
        end else if (w_bit_end) begin
          w_txd_next   = r_shift[0];
          w_shift_next = r_shift >> 1;
          w_bit_next   = r_bit + 4'd1;
        end else begin
          w_state_next = DATA;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_next = STOP;
          w_txd_next   = 1'b1;
          w_stop_next  = 1'b0;
        end else begin
          w_state_next = PARITY;
        end
      end
      STOP: begin
        if (w_bit_end && r_stop == STOP_LAST) begin
`ifdef UART_TX_BREAK_EN
          if (tx_break) begin
            w_state_next = IDLE;
            w_txd_next   = 1'b0;
            w_mark_next  = 1'b1;
          end else if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_txd_next   = 1'b1;
          end
`else
          if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_txd_next   = 1'b1;
          end
`endif
        end else if (w_bit_end) begin
          w_stop_next = 1'b1;
        end else begin
          w_stop_next = r_stop;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_txd_next   = 1'b1;
      end
    endcase
    if (w_load) begin
      w_pop        = 1'b1;
      w_shift_next = w_rdata;
      w_par_next   = w_par_load;
      w_state_next = START;
      w_txd_next   = 1'b0;
      w_baud_next  = '0;
      w_bit_next   = '0;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
`ifdef UART_TX_BREAK_EN
      r_mark  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_stop  <= w_stop_next;
      r_shift <= w_shift_next;
      r_par   <= w_par_next;
      r_txd   <= w_txd_next;
      r_busy  <= (w_state_next != IDLE) || (w_count_next != '0);
      r_ready <= (w_count_next != CW'(FIFO_DEPTH));
`ifdef UART_TX_BREAK_EN
      r_mark  <= w_mark_next;
`endif
    end
  end

  assign txd        = r_txd;
  assign busy       = r_busy;
  assign data_ready = r_ready;
  assign fifo_count = w_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four configurations, per-cycle txd scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PM [4] = '{0, 2, 1, 0};
  localparam int SB [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic [3:0] valid_v, txd_v, busy_v, ready_v;
  logic [4:0] cnt_v [4];
`ifdef UART_TX_BREAK_EN
  logic [3:0] brk_v;
`endif

  int   checks = 0;
  int   errors = 0;
  int   sel = 0;
  logic exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_fifo #(
      .CLKS_PER_BIT(CPB), .CNT_WIDTH(2), .DATA_BITS(DB[g]),
      .PARITY_MODE(PM[g]), .STOP_BITS(SB[g]), .FIFO_DEPTH(16)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (din[DB[g]-1:0]),
      .data_valid (valid_v[g]),
      .data_ready (ready_v[g]),
`ifdef UART_TX_BREAK_EN
      .tx_break   (brk_v[g]),
`endif
      .txd        (txd_v[g]),
      .busy       (busy_v[g]),
      .fifo_count (cnt_v[g])
    );
  end

  // Expected per-cycle txd levels of one frame for the selected configuration
  task automatic append_frame(input logic [7:0] w);
    logic par;
    par = 1'b0;
    if (exp_q.size() == 0) exp_q.push_back(1'b1);
    repeat (CPB) exp_q.push_back(1'b0);
    for (int i = 0; i < DB[sel]; i++) begin
      repeat (CPB) exp_q.push_back(w[i]);
      par = par ^ w[i];
    end
    if (PM[sel] != 0) begin
      if (PM[sel] == 1) par = ~par;
      repeat (CPB) exp_q.push_back(par);
    end
    repeat (SB[sel] * CPB) exp_q.push_back(1'b1);
  endtask

  task automatic tick();
    @(negedge clk);
    if (exp_q.size() > 0) begin
      logic e;
      e = exp_q.pop_front();
      checks++;
      if (txd_v[sel] !== e) begin
        errors++;
        $display("FAIL txd_level inst %0d t=%0t got %b want %b", sel, $time, txd_v[sel], e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    checks++;
    if (ready_v[sel] !== 1'b1) begin
      errors++;
      $display("FAIL push_ready inst %0d got %b want 1", sel, ready_v[sel]);
    end
    din = w;
    valid_v[sel] = 1'b1;
    tick();
    valid_v[sel] = 1'b0;
    append_frame(w);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout inst %0d got %0d left want 0", sel, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy_v[sel] !== 1'b0 || txd_v[sel] !== 1'b1) begin
      errors++;
      $display("FAIL %s inst %0d got busy=%b txd=%b want busy=0 txd=1", name, sel, busy_v[sel], txd_v[sel]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (txd_v !== 4'hF || busy_v !== 4'h0 || ready_v !== 4'h0 || cnt_v[0] !== 5'd0) begin
      errors++;
      $display("FAIL reset_values got txd=%h busy=%h ready=%h cnt=%0d want F 0 0 0", txd_v, busy_v, ready_v, cnt_v[0]);
    end
    reset = 1'b0;
    checks++;
    if (ready_v !== 4'h0) begin
      errors++;
      $display("FAIL ready_early got %h want 0", ready_v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ready_v !== 4'hF) begin
      errors++;
      $display("FAIL ready_rise got %h want F", ready_v);
    end
  endtask

  task automatic test_single(input int inst, input logic [7:0] w);
    sel = inst;
    push_word(w);
    checks++;
    if (busy_v[sel] !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_push inst %0d got %b want 1", sel, busy_v[sel]);
    end
    drain(100);
    check_idle("idle_after_frame");
  endtask

  task automatic test_back_to_back();
    int n;
    sel = 0;
    n = 0;
    valid_v[0] = 1'b1;
    for (int c = 0; c < 40 && ready_v[0] === 1'b1; c++) begin
      din = 8'(n * 37 + 5);
      tick();
      append_frame(din);
      n++;
    end
    valid_v[0] = 1'b0;
    checks++;
    if (n != 17 || cnt_v[0] !== 5'd16) begin
      errors++;
      $display("FAIL fill_count got accepted=%0d cnt=%0d want 17 16", n, cnt_v[0]);
    end
    drain(17 * 40 + 20);
    check_idle("idle_after_burst");
  endtask

  task automatic test_reset_mid();
    int bad;
    sel = 0;
    push_word(8'h41);
    push_word(8'h5A);
    push_word(8'hC3);
    push_word(8'h0F);
    checks++;
    if (cnt_v[0] !== 5'd3) begin
      errors++;
      $display("FAIL queued_count got %0d want 3", cnt_v[0]);
    end
    repeat (12) tick();
    exp_q.delete();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (txd_v[0] !== 1'b1 || cnt_v[0] !== 5'd0 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got txd=%b cnt=%0d busy=%b want 1 0 0", txd_v[0], cnt_v[0], busy_v[0]);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    repeat (100) begin
      tick();
      if (txd_v[0] !== 1'b1 || cnt_v[0] !== 5'd0 || busy_v[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_quiet got %0d bad cycles want 0", bad);
    end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    sel = 0;
    push_word(8'h41);
    repeat (10) exp_q.push_back(1'b0);
    repeat (CPB) exp_q.push_back(1'b1);
    repeat (10) tick();
    brk_v[0] = 1'b1;
    repeat (34) tick();
    push_word(8'h96);
    repeat (5) tick();
    checks++;
    if (cnt_v[0] !== 5'd1) begin
      errors++;
      $display("FAIL break_holds_fifo got %0d want 1", cnt_v[0]);
    end
    brk_v[0] = 1'b0;
    drain(100);
    check_idle("idle_after_break");
  endtask
`endif

  initial begin
    valid_v = 4'h0;
    din = 8'h00;
`ifdef UART_TX_BREAK_EN
    brk_v = 4'h0;
`endif
    test_reset();
    test_single(0, 8'h41);
    test_single(1, 8'h41);
    test_single(2, 8'h41);
    test_single(3, 8'h55);
    test_single(0, 8'hB6);
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, buffered UART transmitter; successor to the fixed 8N1 single-word uart_sender.
- Accepts words over a valid/ready handshake into an internal FIFO.
- Serialises each word with configurable data width, parity and stop bits at a fixed baud divisor.
- Sits between board-level logic (quantum-compiler result stream) and the UART_TXD pin in the DE1 top level.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); must be >= 2
CNT_WIDTH, 9, baud counter width; must satisfy 2**CNT_WIDTH >= CLKS_PER_BIT
DATA_BITS, 8, payload bits per frame, 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of two, >= 2

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-high reset
data_in  in  DATA_BITS  word to transmit
data_valid  in  1  data_in is valid
data_ready  out  1  FIFO can accept; a word transfers when data_valid && data_ready at a clk rising edge
txd  out  1  serial line, idle high
busy  out  1  a frame is in progress, or the FIFO is non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (reset).
- Reset values (asserted immediately, asynchronously): txd=1, busy=0, fifo_count=0, data_ready=0, FSM=IDLE, baud counter=0.
  - data_ready rises on the first clk edge after reset deasserts.
- data_ready = !full; it is a registered output.
  - A push while full cannot occur, even in a cycle where a pop also happens.
  - Push and pop in the same cycle leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit timing: each non-IDLE state bit lasts exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and wraps on the last cycle of each bit.
- IDLE: txd=1. When fifo_count!=0, pop at that edge, load the shift register, enter START with txd<=0.
  - Latency: a word accepted at edge E into an idle, empty block drives txd low after edge E+1.
- START: txd=0 for one bit time, then DATA.
- DATA: transmits DATA_BITS bits, LSB first, one bit time each.
  - Exits to PARITY if PARITY_MODE!=0, otherwise to STOP.
- PARITY: txd = ^data for even parity, ~^data for odd parity; lasts one bit time.
- STOP: txd=1 for STOP_BITS bit times. At the final stop-bit wrap:
  - FIFO non-empty: pop and go directly to START, so there is zero idle gap between frames.
  - FIFO empty: go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- busy = (state!=IDLE) || (fifo_count!=0).
- data_in is don't-care when data_valid=0.
- Reset mid-frame: the frame is aborted, txd returns high immediately, and the FIFO contents are discarded.
- Illegal parameter values (PARITY_MODE>2, STOP_BITS outside 1..2, CLKS_PER_BIT<2) cause an elaboration-time $error.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port tx_break (1 bit).
  - While tx_break=1 in IDLE, txd=0 and no pop occurs.
  - If tx_break asserts mid-frame, the current frame completes first, then the break is held.
  - On release, txd=1 for one full bit time (mark after break) before the next START.
- Undefined: no tx_break port, and break logic is absent.

Decomposition:
- Package uart_pkg holds:
  - parity_mode_e enum (PAR_NONE, PAR_ODD, PAR_EVEN)
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP)
  - localparam function frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS)
- One sub-module, sync_fifo #(WIDTH, DEPTH), provides push/pop, full, empty and count, with same-cycle push/pop support. It is reused elsewhere in the design.

Test Plan:
1. CLKS_PER_BIT=4, 8N1, push 0x41 once -> txd: 0 then 1,0,0,0,0,0,1,0 then 1, each held 4 cycles (40 cycles total); txd falls one edge after accept; busy drops after stop.
2. PARITY_MODE=2, push 0x41 -> parity bit 0 (frame 44 cycles); PARITY_MODE=1 -> parity bit 1.
3. FIFO_DEPTH=16, data_valid held high with an idle block -> 17 words accepted before data_ready falls; all 17 frames emitted back-to-back with no high gap between stop and start.
4. DATA_BITS=7, STOP_BITS=2, push 0x55 -> 7 data bits 1,0,1,0,1,0,1, then 2 stop bit-times high; total 40 cycles at CLKS_PER_BIT=4.
5. Assert reset mid-DATA with 3 words queued -> txd=1 and fifo_count=0 within the same cycle (asynchronous); after release no frame is emitted.
6. (UART_TX_BREAK_EN) tx_break pulsed during a frame -> frame completes, txd low while held, then 4 high cycles before the next START.
